// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader for the instruction memory.
// Accepts a big-endian length word followed by that many big-endian
// instruction words over a valid/ready byte stream, and writes each assembled
// word to consecutive word-aligned addresses starting at BASE_ADDR.

module imem_loader #(
    parameter int          SIZE      = 128,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] word_count
);

    // State encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEN   = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd5;

    localparam logic [31:0] SIZE_W = 32'(SIZE);

    // Shift one stream byte into the low end of a big-endian accumulator.
    function automatic logic [31:0] shift_in(input logic [31:0] acc, input logic [7:0] b);
        return {acc[23:0], b};
    endfunction

    // Byte address of word number idx relative to the load base.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + {idx[29:0], 2'b00};
    endfunction

    // States in which a session is considered in progress.
    function automatic logic is_busy(input logic [2:0] st);
        logic r;
        case (st)
            ST_LEN, ST_DATA, ST_WRITE: r = 1'b1;
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

    // Registered state
    logic [2:0]  state_r;
    logic [31:0] len_r;
    logic [31:0] shift_r;
    logic [1:0]  byte_cnt_r;
    logic [31:0] word_count_r;
    logic        wr_en_r;
    logic [31:0] wr_addr_r;
    logic [31:0] wr_data_r;
    logic        busy_r;
    logic        done_r;
    logic        error_r;

    // Next-state values
    logic [2:0]  state_s;
    logic [31:0] len_s;
    logic [31:0] shift_s;
    logic [1:0]  byte_cnt_s;
    logic [31:0] word_count_s;
    logic        wr_en_s;
    logic [31:0] wr_addr_s;
    logic [31:0] wr_data_s;
    logic        busy_s;
    logic        done_s;
    logic        error_s;
    logic        enter_len_s;
    logic        ready_s;
    logic        accept_s;
    logic [31:0] count_inc_s;

    // in_ready is a pure decode of the current state so the source sees it immediately.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            ST_LEN, ST_DATA: ready_s = 1'b1;
            default:         ready_s = 1'b0;
        endcase
    end

    assign accept_s    = in_valid & ready_s;
    assign count_inc_s = word_count_r + 32'd1;

    // Next-state and datapath update for the load session sequencer.
    always_comb begin
        state_s      = state_r;
        len_s        = len_r;
        shift_s      = shift_r;
        byte_cnt_s   = byte_cnt_r;
        word_count_s = word_count_r;
        wr_en_s      = 1'b0;
        wr_addr_s    = wr_addr_r;
        wr_data_s    = wr_data_r;
        enter_len_s  = 1'b0;

        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    enter_len_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_LEN: begin
                if (accept_s) begin
                    len_s      = shift_in(len_r, in_data);
                    byte_cnt_s = byte_cnt_r + 2'd1;
                    if (byte_cnt_r == 2'd3) begin
                        if (len_s == 32'd0) begin
                            state_s = ST_DONE;
                        end else if (len_s > SIZE_W) begin
                            state_s = ST_ERR;
                        end else begin
                            state_s = ST_DATA;
                        end
                    end else begin
                        state_s = ST_LEN;
                    end
                end else begin
                    state_s = ST_LEN;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    shift_s    = shift_in(shift_r, in_data);
                    byte_cnt_s = byte_cnt_r + 2'd1;
                    if (byte_cnt_r == 2'd3) begin
                        // Launch the write strobe together with entry to WRITE.
                        state_s   = ST_WRITE;
                        wr_en_s   = 1'b1;
                        wr_data_s = shift_s;
                        wr_addr_s = word_addr(BASE_ADDR, word_count_r);
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_WRITE: begin
                word_count_s = count_inc_s;
                if (count_inc_s == len_r) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DATA;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // A new session always starts from a clean slate.
        if (enter_len_s) begin
            state_s      = ST_LEN;
            len_s        = 32'd0;
            shift_s      = 32'd0;
            byte_cnt_s   = 2'd0;
            word_count_s = 32'd0;
        end else begin
            byte_cnt_s = byte_cnt_s;
        end

        busy_s  = is_busy(state_s);
        done_s  = (state_s == ST_DONE);
        error_s = (state_s == ST_ERR);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            len_r        <= 32'd0;
            shift_r      <= 32'd0;
            byte_cnt_r   <= 2'd0;
            word_count_r <= 32'd0;
            wr_en_r      <= 1'b0;
            wr_addr_r    <= 32'd0;
            wr_data_r    <= 32'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            len_r        <= len_s;
            shift_r      <= shift_s;
            byte_cnt_r   <= byte_cnt_s;
            word_count_r <= word_count_s;
            wr_en_r      <= wr_en_s;
            wr_addr_r    <= wr_addr_s;
            wr_data_r    <= wr_data_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            error_r      <= error_s;
        end
    end

    assign in_ready   = ready_s;
    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;
    assign word_count = word_count_r;

    imem_loader_checker u_checker (
        .clk      (clk),
        .reset    (reset),
        .in_ready (ready_s),
        .wr_en    (wr_en_r),
        .wr_addr  (wr_addr_r),
        .busy     (busy_r),
        .done     (done_r),
        .error    (error_r)
    );

endmodule

// Protocol invariants of the loader outputs.
module imem_loader_checker (
    input logic        clk,
    input logic        reset,
    input logic        in_ready,
    input logic        wr_en,
    input logic [31:0] wr_addr,
    input logic        busy,
    input logic        done,
    input logic        error
);

    // A write cycle never accepts a byte.
    a_write_blocks_input: assert property (@(posedge clk) disable iff (!reset) wr_en |-> !in_ready)
        else $error("imem_loader: in_ready high during write");

    // Write addresses are always word aligned.
    a_addr_aligned: assert property (@(posedge clk) disable iff (!reset) wr_en |-> (wr_addr[1:0] == 2'b00))
        else $error("imem_loader: unaligned write address");

    // Terminal flags are exclusive and imply the session has ended.
    a_flags_exclusive: assert property (@(posedge clk) disable iff (!reset) !(done && error))
        else $error("imem_loader: done and error both set");

    a_flags_not_busy: assert property (@(posedge clk) disable iff (!reset) (done || error) |-> !busy)
        else $error("imem_loader: busy with terminal flag set");

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: two instances (base 0x0 and 0x100) share
// one randomized byte stream; expected writes are queued per instance when a
// word is issued and popped by independent monitors on each write strobe.

module tb_imem_loader;

    localparam logic [31:0] BASE0 = 32'h0;
    localparam logic [31:0] BASE1 = 32'h100;
    localparam logic [31:0] SIZE  = 32'd128;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;

    logic        rdy0, wen0, busy0, done0, err0;
    logic [31:0] addr0, data0, wc0;
    logic        rdy1, wen1, busy1, done1, err1;
    logic [31:0] addr1, data1, wc1;

    int checks = 0;
    int failures = 0;

    wr_t         q0[$];
    wr_t         q1[$];
    logic [31:0] stim_words[$];

    always #5 clk = ~clk;

    imem_loader #(.SIZE(128), .BASE_ADDR(BASE0)) u0 (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy0), .wr_en(wen0), .wr_addr(addr0), .wr_data(data0),
        .busy(busy0), .done(done0), .error(err0), .word_count(wc0)
    );

    imem_loader #(.SIZE(128), .BASE_ADDR(BASE1)) u1 (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy1), .wr_en(wen1), .wr_addr(addr1), .wr_data(data1),
        .busy(busy1), .done(done1), .error(err1), .word_count(wc1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor for the base-0 instance.
    always @(negedge clk) begin
        if (wen0 === 1'b1) begin
            wr_t e;
            chk("wr0_in_ready", {31'd0, rdy0}, 32'd0);
            if (q0.size() == 0) begin
                chk("wr0_unexpected", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                chk("wr0_addr", addr0, e.addr);
                chk("wr0_data", data0, e.data);
            end
        end
    end

    // Monitor for the base-0x100 instance.
    always @(negedge clk) begin
        if (wen1 === 1'b1) begin
            wr_t e;
            chk("wr1_in_ready", {31'd0, rdy1}, 32'd0);
            if (q1.size() == 0) begin
                chk("wr1_unexpected", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("wr1_addr", addr1, e.addr);
                chk("wr1_data", data1, e.data);
            end
        end
    end

    // Offer one byte (after optional random idle gaps) until it is accepted.
    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        logic accepted;
        int   waited;
        while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        accepted = 1'b0;
        waited   = 0;
        while (!accepted && waited < 200) begin
            accepted = rdy0;
            @(negedge clk);
            waited++;
        end
        if (!accepted) begin
            chk("byte_accept_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_pct);
        logic [31:0] tmp;
        tmp = w;
        for (int k = 0; k < 4; k++) begin
            send_byte(tmp[31:24], gap_pct);
            tmp = {tmp[23:0], 8'h00};
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_state();
        chk("rst_in_ready", {31'd0, rdy0}, 32'd0);
        chk("rst_wr_en", {31'd0, wen0}, 32'd0);
        chk("rst_wr_addr", addr0, 32'd0);
        chk("rst_wr_addr1", addr1, 32'd0);
        chk("rst_wr_data", data0, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_done", {31'd0, done0}, 32'd0);
        chk("rst_error", {31'd0, err0}, 32'd0);
        chk("rst_word_count", wc0, 32'd0);
    endtask

    // One full session: start, length, words; model predicts all writes and final flags.
    task automatic run_session(input logic [31:0] n, input int gap_pct, input bit start_mid);
        logic [31:0] w;
        int          waited;
        wr_t         e;
        pulse_start();
        chk("start_busy", {31'd0, busy0}, 32'd1);
        chk("start_done_clr", {31'd0, done0}, 32'd0);
        chk("start_err_clr", {31'd0, err0}, 32'd0);
        send_word(n, gap_pct);
        if (n == 32'd0) begin
            chk("n0_done", {31'd0, done0}, 32'd1);
            chk("n0_busy", {31'd0, busy0}, 32'd0);
            chk("n0_word_count", wc0, 32'd0);
        end else if (n > SIZE) begin
            chk("ovf_error", {31'd0, err0}, 32'd1);
            chk("ovf_in_ready", {31'd0, rdy0}, 32'd0);
            chk("ovf_busy", {31'd0, busy0}, 32'd0);
            chk("ovf_done", {31'd0, done0}, 32'd0);
            chk("ovf_word_count", wc0, 32'd0);
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                w = (i < stim_words.size()) ? stim_words[i] : $urandom;
                e.data = w;
                e.addr = BASE0 + 32'(4 * i);
                q0.push_back(e);
                e.addr = BASE1 + 32'(4 * i);
                q1.push_back(e);
                send_word(w, gap_pct);
                if (start_mid && i == 0) begin
                    in_valid = 1'b0;
                    pulse_start();
                    chk("mid_start_busy", {31'd0, busy0}, 32'd1);
                end
            end
            waited = 0;
            @(negedge clk);
            while (!(done0 || err0) && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            chk("end_done", {31'd0, done0}, 32'd1);
            chk("end_error", {31'd0, err0}, 32'd0);
            chk("end_busy", {31'd0, busy0}, 32'd0);
            chk("end_word_count", wc0, n);
            chk("end_word_count1", wc1, n);
            chk("end_q0_empty", 32'(q0.size()), 32'd0);
            chk("end_q1_empty", 32'(q1.size()), 32'd0);
        end
        stim_words.delete();
        repeat (2) @(negedge clk);
    endtask

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        wr_t         e;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state();
        reset = 1'b1;
        @(negedge clk);

        // Directed four-word program, no gaps.
        stim_words = '{32'h00011020, 32'h00642820, 32'hAE010000, 32'h8E040000};
        run_session(32'd4, 0, 1'b0);

        // Empty load.
        run_session(32'd0, 0, 1'b0);

        // Oversized length, then recovery.
        run_session(32'd129, 0, 1'b0);
        stim_words = '{32'hDEADBEEF};
        run_session(32'd1, 0, 1'b0);

        // Random gaps.
        run_session(32'd2, 40, 1'b0);

        // Reset in the middle of the second word.
        pulse_start();
        send_word(32'd2, 0);
        w = $urandom;
        e.data = w;
        e.addr = BASE0;
        q0.push_back(e);
        e.addr = BASE1;
        q1.push_back(e);
        send_word(w, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h5A, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state();
        chk("midrst_q0_empty", 32'(q0.size()), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        run_session(32'd1, 0, 1'b0);

        // start during DATA is ignored.
        run_session(32'd3, 30, 1'b1);

        // Randomized sessions.
        for (int s = 0; s < 6; s++) begin
            run_session(32'($urandom_range(0, 6)), int'($urandom_range(0, 50)), 1'b0);
        end
        run_session(32'($urandom_range(129, 100000)), 20, 1'b0);
        run_session(32'd128, 0, 1'b0);

        repeat (5) @(negedge clk);
        chk("final_q0_empty", 32'(q0.size()), 32'd0);
        chk("final_q1_empty", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the instruction memory.
- Receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into instruction memory through a one-cycle write strobe at word-aligned byte addresses.
- Sits between the host/boot byte source and the instruction memory write port. Runs before the core starts fetching.

Parameters:
- SIZE, 128, instruction memory depth in 32-bit words; maximum loadable word count.
- BASE_ADDR, 32'h0, byte address of the first word written; must be a multiple of 4.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load session.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte this cycle.
- wr_en  output  1  one-cycle write strobe to instruction memory.
- wr_addr  output  32  byte address of the word being written (multiple of 4).
- wr_data  output  32  instruction word to write.
- busy  output  1  session in progress (LEN, DATA or WRITE state).
- done  output  1  session completed successfully; held.
- error  output  1  length rejected; held.
- word_count  output  32  number of words written in the current/last session.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, word_count=0. Byte shift register, byte counter and length register are cleared.
- Reset mid-session: any partial word is discarded and no write is issued.
- Byte transfer occurs on a clk edge where in_valid && in_ready. in_data is ignored otherwise.
- in_ready is combinational from state: 1 in LEN and DATA, 0 elsewhere.
- Stream format, all values big-endian (first byte = bits 31:24):
  - 4 bytes: length N.
  - then N words of 4 bytes each.
- States:
  - IDLE: waits for start → LEN.
  - LEN: accepts 4 bytes into the length register. After the 4th byte:
    - N==0 → DONE.
    - N>SIZE → ERR.
    - otherwise → DATA.
  - DATA: accepts bytes into a 32-bit shift register (shift left by 8, new byte into bits 7:0). After the 4th byte → WRITE.
  - WRITE: exactly one cycle. wr_en=1, wr_data=assembled word, wr_addr=BASE_ADDR+4*word_count (pre-increment value). word_count increments at the end of this cycle. Next state:
    - DONE if the new word_count==N.
    - DATA otherwise.
  - DONE: done=1, busy=0. start → LEN.
  - ERR: error=1, busy=0. start → LEN.
- Entering LEN from any state: clears done, error, word_count, byte counter and length register.
- start while in LEN, DATA or WRITE is ignored. start in IDLE, DONE or ERR is honoured.
- Latency: if the 4th byte of a word is accepted at edge t, wr_en is high during cycle t..t+1. There are at most 4 byte-accept cycles per write, plus 1 WRITE bubble.
- wr_en is never high outside WRITE. wr_addr and wr_data hold their last values when wr_en=0.
- All-zero words are written like any other word; the loader does not interpret content.
- Word-count arithmetic is unsigned 32-bit. Address width is 32 bits; no wrap is possible because N≤SIZE.
- in_valid may toggle arbitrarily; gaps between bytes only stall the session. No timeout.
- busy==1 exactly in LEN, DATA and WRITE.

Test Plan:
- Reset then stream N=4 followed by 00 01 10 20, 00 64 28 20, AE 01 00 00, 8E 04 00 00 with in_valid held high → 4 wr_en pulses:
  - (0x0, 0x00011020)
  - (0x4, 0x00642820)
  - (0x8, 0xAE010000)
  - (0xC, 0x8E040000)
  - then done=1, word_count=4, busy=0.
- N=0 → no wr_en, done=1 the cycle after the 4th length byte, word_count=0.
- N=129 with SIZE=128 → error=1, in_ready=0, no wr_en. Then start with N=1, word DEADBEEF → write (0x0, 0xDEADBEEF), error=0, done=1.
- Random in_valid gaps with N=2, BASE_ADDR=0x100:
  - writes at 0x100 and 0x104 with correct data.
  - in_ready=0 in every WRITE cycle.
  - bytes offered during WRITE are not consumed.
- Drive reset=0 after 2 bytes of the second word, release, then start with N=1 → no write from the partial word; new session writes address BASE_ADDR with word_count=1.
- start pulsed during DATA → ignored; session completes with the original N and addresses.
